// File: rtl/regs_bus_if.sv
// Request/acknowledge register bus between the system bus adapter and a register bank.
interface regs_bus_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic              WR_REQ;
  logic              RD_REQ;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WD;
  logic              ACK;
  logic [DATA_W-1:0] RD;
  logic              ERR;

  modport master (output WR_REQ, RD_REQ, ADDR, WD, input ACK, RD, ERR);
  modport slave  (input WR_REQ, RD_REQ, ADDR, WD, output ACK, RD, ERR);
endinterface

// File: rtl/regs_bus_slave.sv
// Register bank front end: CTRL read/write registers, sticky W1C STATUS, IRQ_EN and IRQ.
module regs_bus_slave #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned REG_N  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  regs_bus_if.slave                bus,
  output logic [REG_N*DATA_W-1:0]  CTRL,
  output logic [REG_N-1:0]         CTRL_WE,
  input  logic [DATA_W-1:0]        STS_EVT,
  output logic                     IRQ
);

  localparam logic [ADDR_W-1:0] STS_ADDR = ADDR_W'(REG_N);
  localparam logic [ADDR_W-1:0] IEN_ADDR = ADDR_W'(REG_N + 1);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] ctrl_q [REG_N];
  logic [DATA_W-1:0] sts_q;
  logic [DATA_W-1:0] ien_q;

  logic [DATA_W-1:0] rd_mux_c;
  logic              hit_c;
  logic              wr_acc_c;
  logic [DATA_W-1:0] sts_clr_c;

  // Address decode and read mux
  always_comb begin
    rd_mux_c = '0;
    hit_c    = 1'b0;
    for (int unsigned k = 0; k < REG_N; k++) begin
      if (bus.ADDR == ADDR_W'(k)) begin
        rd_mux_c = ctrl_q[k];
        hit_c    = 1'b1;
      end
    end
    if (bus.ADDR == STS_ADDR) begin
      rd_mux_c = sts_q;
      hit_c    = 1'b1;
    end
    if (bus.ADDR == IEN_ADDR) begin
      rd_mux_c = ien_q;
      hit_c    = 1'b1;
    end
  end

  assign wr_acc_c  = (state_q == S_IDLE) && bus.WR_REQ;
  assign sts_clr_c = (wr_acc_c && (bus.ADDR == STS_ADDR)) ? bus.WD : '0;

  // Bus FSM, register writes and sticky status; events override a same-edge clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      bus.ACK <= 1'b0;
      bus.RD  <= '0;
      bus.ERR <= 1'b0;
      CTRL_WE <= '0;
      sts_q   <= '0;
      ien_q   <= '0;
      for (int unsigned k = 0; k < REG_N; k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      bus.ACK <= 1'b0;
      bus.RD  <= '0;
      bus.ERR <= 1'b0;
      CTRL_WE <= '0;
      sts_q   <= (sts_q & ~sts_clr_c) | STS_EVT;
      case (state_q)
        S_IDLE: begin
          if (bus.WR_REQ) begin
            state_q <= S_ACK;
            bus.ACK <= 1'b1;
            bus.ERR <= !hit_c;
            for (int unsigned k = 0; k < REG_N; k++) begin
              if (bus.ADDR == ADDR_W'(k)) begin
                ctrl_q[k]  <= bus.WD;
                CTRL_WE[k] <= 1'b1;
              end
            end
            if (bus.ADDR == IEN_ADDR) begin
              ien_q <= bus.WD;
            end
          end else if (bus.RD_REQ) begin
            state_q <= S_ACK;
            bus.ACK <= 1'b1;
            bus.RD  <= rd_mux_c;
            bus.ERR <= !hit_c;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < int'(REG_N); g++) begin : g_ctrl
    assign CTRL[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign IRQ = |(sts_q & ien_q);

endmodule

// File: tb/tb_regs_bus_slave.sv
// Scoreboard bench for regs_bus_slave with REG_N=4, DATA_W=32, ADDR_W=4.
module tb_regs_bus_slave;

  logic         CLK;
  logic         RST;
  logic [127:0] CTRL;
  logic [3:0]   CTRL_WE;
  logic [31:0]  STS_EVT;
  logic         IRQ;

  regs_bus_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  regs_bus_slave #(.DATA_W(32), .ADDR_W(4), .REG_N(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .CTRL    (CTRL),
    .CTRL_WE (CTRL_WE),
    .STS_EVT (STS_EVT),
    .IRQ     (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [3:0]  we;
  } exp_t;

  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_ctrl [4];
  logic [31:0] m_sts;
  logic [31:0] m_ien;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    if (a < 4'd4)  return m_ctrl[a[1:0]];
    if (a == 4'd4) return m_sts;
    if (a == 4'd5) return m_ien;
    return 32'h0;
  endfunction

  function automatic logic [127:0] model_flat();
    return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ctrl[i] = 32'h0;
    m_sts = 32'h0;
    m_ien = 32'h0;
  endtask

  // Drive one transaction, then pop the expectation when ACK appears
  task automatic xfer(input bit wr, input bit rd, input logic [3:0] a,
                      input logic [31:0] wd, input logic [31:0] evt);
    exp_t e;
    exp_t g;
    int   wait_n;
    bit   seen;
    e.err = (a > 4'd5);
    e.rd  = 32'h0;
    e.we  = 4'h0;
    if (wr) begin
      if (a < 4'd4) e.we = 4'(1 << a);
    end else if (rd) begin
      e.rd = model_rd(a);
    end
    sb.push_back(e);
    bus.WR_REQ = wr;
    bus.RD_REQ = rd;
    bus.ADDR   = a;
    bus.WD     = wd;
    STS_EVT    = evt;
    @(posedge CLK);
    #1 STS_EVT = 32'h0;
    if (wr && a == 4'd4) m_sts = (m_sts & ~wd) | evt;
    else                 m_sts = m_sts | evt;
    if (wr && a < 4'd4)  m_ctrl[a[1:0]] = wd;
    if (wr && a == 4'd5) m_ien = wd;
    seen   = 1'b0;
    wait_n = 0;
    while (!seen && wait_n < 8) begin
      @(negedge CLK);
      wait_n++;
      if (bus.ACK) seen = 1'b1;
    end
    if (!seen) begin
      chk("ack_timeout", 128'(seen), 128'(1));
    end else begin
      g = sb.pop_front();
      chk("rd",      128'(bus.RD),  128'(g.rd));
      chk("err",     128'(bus.ERR), 128'(g.err));
      chk("ctrl_we", 128'(CTRL_WE), 128'(g.we));
      chk("ctrl",    CTRL,          model_flat());
      chk("irq",     128'(IRQ),     128'(|(m_sts & m_ien)));
      @(negedge CLK);
      chk("ack_one_cycle", 128'(bus.ACK), 128'(0));
      chk("rd_idle",       128'(bus.RD),  128'(0));
      chk("we_idle",       128'(CTRL_WE), 128'(0));
    end
    bus.WR_REQ = 1'b0;
    bus.RD_REQ = 1'b0;
  endtask

  task automatic pulse_evt(input logic [31:0] v);
    STS_EVT = v;
    @(posedge CLK);
    #1 STS_EVT = 32'h0;
    m_sts = m_sts | v;
    @(negedge CLK);
    chk("evt_irq", 128'(IRQ), 128'(|(m_sts & m_ien)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  128'(bus.ACK), 128'(0));
    chk({tag, "_rd"},   128'(bus.RD),  128'(0));
    chk({tag, "_err"},  128'(bus.ERR), 128'(0));
    chk({tag, "_ctrl"}, CTRL,          128'(0));
    chk({tag, "_we"},   128'(CTRL_WE), 128'(0));
    chk({tag, "_irq"},  128'(IRQ),     128'(0));
  endtask

  initial begin
    RST        = 1'b0;
    bus.WR_REQ = 1'b0;
    bus.RD_REQ = 1'b0;
    bus.ADDR   = 4'h0;
    bus.WD     = 32'h0;
    STS_EVT    = 32'h0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_all_zero("in_reset");
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk_all_zero("after_reset");

    for (int a = 0; a < 6; a++) xfer(1'b0, 1'b1, 4'(a), 32'h0, 32'h0);

    xfer(1'b1, 1'b0, 4'd2, 32'hDEADBEEF, 32'h0);
    chk("ctrl2_slice", 128'(CTRL[95:64]), 128'(32'hDEADBEEF));
    xfer(1'b0, 1'b1, 4'd2, 32'h0, 32'h0);

    pulse_evt(32'h5);
    xfer(1'b0, 1'b1, 4'd4, 32'h0, 32'h0);
    xfer(1'b1, 1'b0, 4'd5, 32'h4, 32'h0);
    chk("irq_set", 128'(IRQ), 128'(1));
    xfer(1'b1, 1'b0, 4'd4, 32'h4, 32'h0);
    chk("irq_clr", 128'(IRQ), 128'(0));
    xfer(1'b0, 1'b1, 4'd4, 32'h0, 32'h0);

    xfer(1'b1, 1'b0, 4'd4, 32'h1, 32'h1);
    xfer(1'b0, 1'b1, 4'd4, 32'h0, 32'h0);

    xfer(1'b1, 1'b0, 4'd9, 32'hFFFFFFFF, 32'h0);
    xfer(1'b0, 1'b1, 4'd9, 32'h0, 32'h0);
    xfer(1'b1, 1'b1, 4'd1, 32'h12345678, 32'h0);
    xfer(1'b0, 1'b1, 4'd1, 32'h0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      xfer(1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 7)), $urandom(),
           32'($urandom_range(0, 3)));
    end

    // Abort a read with reset right after its request edge
    bus.RD_REQ = 1'b1;
    bus.ADDR   = 4'd2;
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 chk_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("abort_no_ack", 128'(bus.ACK), 128'(0));
    end
    bus.RD_REQ = 1'b0;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    xfer(1'b0, 1'b1, 4'd2, 32'h0, 32'h0);
    xfer(1'b1, 1'b0, 4'd0, 32'hA5A5_0F0F, 32'h0);
    xfer(1'b0, 1'b1, 4'd0, 32'h0, 32'h0);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
